// File: rtl/shot_sequencer.sv
// Shot sequencer: issues one trigger per shot and waits for the timing and capture handshakes.
// Optional macro SEQ_TIMEOUT_EN adds a WAIT_SC/COLLECT watchdog that raises the sticky error flag.
module shot_sequencer #(
  parameter int SHOTS_W     = 16,
  parameter int DELAY_W     = 14,
  parameter int HOLD_W      = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk100,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [SHOTS_W-1:0] num_shots,
  input  logic [DELAY_W-1:0] delay_cfg,
  input  logic [HOLD_W-1:0]  holdoff,
  input  logic               start_collect,
  input  logic               collect_done,
  output logic               trigger,
  output logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic [SHOTS_W-1:0] shot_idx,
  output logic               run_done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_SC,
    COLLECT,
    HOLD,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SHOTS_W-1:0] num_q, num_d;
  logic [SHOTS_W-1:0] idx_q, idx_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [HOLD_W-1:0]  hold_cfg_q, hold_cfg_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tmo_hit;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      idx_q      <= '0;
      delay_q    <= '0;
      hold_cfg_q <= '0;
      hold_cnt_q <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      delay_q    <= delay_d;
      hold_cfg_q <= hold_cfg_d;
      hold_cnt_q <= hold_cnt_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are registered from the next state so trigger/busy line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    delay_d    = delay_q;
    hold_cfg_d = hold_cfg_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_d      = num_shots;
          delay_d    = delay_cfg;
          hold_cfg_d = holdoff;
          idx_d      = '0;
          state_d    = (num_shots == '0) ? DONE : TRIG;
        end
      end
      TRIG: state_d = WAIT_SC;
      WAIT_SC: begin
        if (start_collect) begin
          state_d = COLLECT;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (collect_done) begin
          idx_d = idx_q + SHOTS_W'(1);
          if (idx_d == num_q) begin
            state_d = DONE;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = hold_cfg_q;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d = TRIG;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      idx_d      = idx_q;
      hold_cnt_d = hold_cnt_q;
    end

    trig_d = (state_d == TRIG);
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE) && !abort;
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             waiting;
  logic             progress;

  assign waiting  = (state_q == WAIT_SC) || (state_q == COLLECT);
  assign progress = ((state_q == WAIT_SC) && start_collect) ||
                    ((state_q == COLLECT) && collect_done);
  assign tmo_hit  = waiting && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // The count restarts whenever the FSM changes state, so each wait is timed on its own.
  always_comb begin
    tmo_d = '0;
    if (waiting && (state_d == state_q)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    err_d = err_q;
    if ((state_q == IDLE) && start && !abort) begin
      err_d = 1'b0;
    end
    if (tmo_hit && !progress && !abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign tmo_hit = 1'b0;
  assign error   = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  assign trigger  = trig_q;
  assign delay    = delay_q;
  assign busy     = busy_q;
  assign shot_idx = idx_q;
  assign run_done = done_q;

endmodule
